// File: rtl/multiexp_dispatch.sv
// multiexp_dispatch: spreads a point/scalar stream over NUM_CORES external
// multiexp cores, KEY_BITS passes of N items each, then folds the per-core
// results together through an external point adder and emits the sum.
// Optional feature macro: MULTIEXP_DISPATCH_STATS_EN adds stall/run counters.
module multiexp_dispatch #(
    parameter int NUM_CORES = 4,
    parameter int KEY_BITS  = 256,
    parameter int PNT_BITS  = 768,
    parameter int CNT_BITS  = 64
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [CNT_BITS-1:0]              i_num_in,
    output logic                             o_busy,
    input  logic                             i_pnt_scl_val,
    output logic                             o_pnt_scl_rdy,
    input  logic [PNT_BITS+KEY_BITS-1:0]     i_pnt_scl_dat,
    output logic [NUM_CORES-1:0]             o_core_val,
    input  logic [NUM_CORES-1:0]             i_core_rdy,
    output logic [PNT_BITS+KEY_BITS-1:0]     o_core_dat,
    output logic [NUM_CORES*CNT_BITS-1:0]    o_core_num_in,
    input  logic [NUM_CORES-1:0]             i_core_res_val,
    output logic [NUM_CORES-1:0]             o_core_res_rdy,
    input  logic [NUM_CORES*PNT_BITS-1:0]    i_core_res_dat,
    output logic                             o_add_val,
    input  logic                             i_add_rdy,
    output logic [2*PNT_BITS-1:0]            o_add_dat,
    input  logic                             i_add_res_val,
    output logic                             o_add_res_rdy,
    input  logic [PNT_BITS-1:0]              i_add_res_dat,
    output logic                             o_pnt_val,
    input  logic                             i_pnt_rdy,
    output logic [PNT_BITS-1:0]              o_pnt_dat
`ifdef MULTIEXP_DISPATCH_STATS_EN
    ,
    output logic [31:0]                      o_stall_cnt,
    output logic [31:0]                      o_run_cnt
`endif
);

    localparam int SEL_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PASS_W = $clog2(KEY_BITS + 1);
    localparam int DIVC_W = $clog2(CNT_BITS + 1);
    // remainder never exceeds 15, so one shifted-in bit fits in 6 bits
    localparam int REM_W  = 6;

    localparam logic [REM_W-1:0]  DIVISOR   = REM_W'(NUM_CORES);
    localparam logic [SEL_W-1:0]  SEL_MAX   = SEL_W'(NUM_CORES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(KEY_BITS - 1);
    localparam logic [DIVC_W-1:0] DIV_LAST  = DIVC_W'(CNT_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DIV      = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_REDUCE   = 3'd3,
        ST_OUTPUT   = 3'd4
    } state_t;

    // reduce sub-phase: load core 0, issue an add, wait for its result
    typedef enum logic [1:0] {
        RD_LOAD  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2
    } red_t;

    state_t                        state_r;
    state_t                        state_next_s;
    red_t                          red_r;

    logic [CNT_BITS-1:0]           num_r;
    logic [CNT_BITS-1:0]           quo_r;
    logic [REM_W-1:0]              rem_r;
    logic [DIVC_W-1:0]             div_cnt_r;
    logic [REM_W-1:0]              rem_shift_s;
    logic [REM_W-1:0]              rem_next_s;
    logic [CNT_BITS-1:0]           quo_next_s;

    logic [NUM_CORES*CNT_BITS-1:0] core_num_r;
    logic [NUM_CORES*CNT_BITS-1:0] num_calc_s;
    logic [SEL_W-1:0]              last_core_r;
    logic [SEL_W-1:0]              last_calc_s;

    logic [SEL_W-1:0]              sel_r;
    logic [CNT_BITS-1:0]           in_cnt_r;
    logic [PASS_W-1:0]             pass_cnt_r;

    logic [SEL_W-1:0]              idx_r;
    logic [PNT_BITS-1:0]           acc_r;
    logic [PNT_BITS-1:0]           operand_r;
    logic                          load_rdy_r;
    logic                          add_val_r;
    logic                          add_res_rdy_r;
    logic                          pnt_val_r;

    logic                          core_rdy_sel_s;
    logic                          res_val_sel_s;
    logic [PNT_BITS-1:0]           res_dat_sel_s;

    logic                          start_ok_s;
    logic                          div_done_s;
    logic                          xfer_s;
    logic                          last_item_s;
    logic                          last_pass_s;
    logic                          load_fire_s;
    logic                          add_fire_s;
    logic                          res_fire_s;
    logic                          last_idx_s;
    logic                          out_fire_s;

    // one restoring-division step plus per-core counts derived from its result
    always_comb begin
        rem_shift_s = {rem_r[REM_W-2:0], quo_r[CNT_BITS-1]};
        rem_next_s  = rem_shift_s;
        quo_next_s  = {quo_r[CNT_BITS-2:0], 1'b0};
        num_calc_s  = '0;
        last_calc_s = SEL_MAX;
        if (rem_shift_s >= DIVISOR) begin
            rem_next_s = rem_shift_s - DIVISOR;
            quo_next_s = {quo_r[CNT_BITS-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s;
            quo_next_s = {quo_r[CNT_BITS-2:0], 1'b0};
        end
        for (int c = 0; c < NUM_CORES; c++) begin
            num_calc_s[c*CNT_BITS +: CNT_BITS] = quo_next_s +
                ((REM_W'(c) < rem_next_s) ? CNT_BITS'(1) : CNT_BITS'(0));
        end
        // fewer items than cores: only the first r cores are active
        last_calc_s = (quo_next_s == '0) ? SEL_W'(rem_next_s - REM_W'(1)) : SEL_MAX;
    end

    // select the ready of the current dispatch target and the result of the reduce target
    always_comb begin
        core_rdy_sel_s = 1'b0;
        res_val_sel_s  = 1'b0;
        res_dat_sel_s  = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            core_rdy_sel_s = (sel_r == SEL_W'(c)) ? i_core_rdy[c] : core_rdy_sel_s;
            res_val_sel_s  = (idx_r == SEL_W'(c)) ? i_core_res_val[c] : res_val_sel_s;
            res_dat_sel_s  = (idx_r == SEL_W'(c)) ? i_core_res_dat[c*PNT_BITS +: PNT_BITS]
                                                  : res_dat_sel_s;
        end
    end

    assign start_ok_s  = (state_r == ST_IDLE) && i_start;
    assign div_done_s  = (state_r == ST_DIV) && (div_cnt_r == DIV_LAST);
    assign xfer_s      = i_pnt_scl_val && o_pnt_scl_rdy;
    assign last_item_s = (in_cnt_r == (num_r - CNT_BITS'(1)));
    assign last_pass_s = (pass_cnt_r == PASS_LAST);
    assign load_fire_s = (state_r == ST_REDUCE) && (red_r == RD_LOAD) && i_core_res_val[0];
    assign add_fire_s  = add_val_r && i_add_rdy;
    assign res_fire_s  = (state_r == ST_REDUCE) && (red_r == RD_WAIT) && add_res_rdy_r && i_add_res_val;
    assign last_idx_s  = (idx_r == last_core_r);
    assign out_fire_s  = pnt_val_r && i_pnt_rdy;

    // dispatch path is combinational so a stalled core stalls the stream in the same cycle
    always_comb begin
        o_pnt_scl_rdy = (state_r == ST_DISPATCH) && core_rdy_sel_s;
        o_core_dat    = i_pnt_scl_dat;
        o_core_val    = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            o_core_val[c] = (state_r == ST_DISPATCH) && i_pnt_scl_val && (sel_r == SEL_W'(c));
        end
    end

    // core 0 is acknowledged by the load pulse, later cores together with their add handshake
    always_comb begin
        o_core_res_rdy    = '0;
        o_core_res_rdy[0] = load_rdy_r;
        for (int c = 1; c < NUM_CORES; c++) begin
            o_core_res_rdy[c] = add_fire_s && (idx_r == SEL_W'(c));
        end
    end

    assign o_busy        = (state_r != ST_IDLE);
    assign o_core_num_in = core_num_r;
    assign o_add_val     = add_val_r;
    assign o_add_dat     = {acc_r, operand_r};
    assign o_add_res_rdy = add_res_rdy_r;
    assign o_pnt_val     = pnt_val_r;
    assign o_pnt_dat     = acc_r;

    // next-state selection for the top-level sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) state_next_s = ST_DIV;
                else         state_next_s = ST_IDLE;
            end
            ST_DIV: begin
                if (div_done_s) state_next_s = (num_r == '0) ? ST_OUTPUT : ST_DISPATCH;
                else            state_next_s = ST_DIV;
            end
            ST_DISPATCH: begin
                if (xfer_s && last_item_s && last_pass_s) state_next_s = ST_REDUCE;
                else                                      state_next_s = ST_DISPATCH;
            end
            ST_REDUCE: begin
                if (load_fire_s && (last_core_r == '0))  state_next_s = ST_OUTPUT;
                else if (res_fire_s && last_idx_s)       state_next_s = ST_OUTPUT;
                else                                     state_next_s = ST_REDUCE;
            end
            ST_OUTPUT: begin
                if (out_fire_s) state_next_s = ST_IDLE;
                else            state_next_s = ST_OUTPUT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // restoring divider: N / NUM_CORES over exactly CNT_BITS cycles
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            num_r     <= '0;
            quo_r     <= '0;
            rem_r     <= '0;
            div_cnt_r <= '0;
        end else if (start_ok_s) begin
            num_r     <= i_num_in;
            quo_r     <= i_num_in;
            rem_r     <= '0;
            div_cnt_r <= '0;
        end else if (state_r == ST_DIV) begin
            quo_r     <= quo_next_s;
            rem_r     <= rem_next_s;
            div_cnt_r <= div_cnt_r + DIVC_W'(1);
        end
    end

    // per-core counts and last active core, held from end of divide until back in IDLE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            core_num_r  <= '0;
            last_core_r <= '0;
        end else if (div_done_s) begin
            core_num_r  <= num_calc_s;
            last_core_r <= last_calc_s;
        end else if (out_fire_s) begin
            core_num_r  <= '0;
        end
    end

    // round-robin target, item and pass counters; every pass restarts at core 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_r      <= '0;
            in_cnt_r   <= '0;
            pass_cnt_r <= '0;
        end else if (start_ok_s) begin
            sel_r      <= '0;
            in_cnt_r   <= '0;
            pass_cnt_r <= '0;
        end else if (xfer_s) begin
            if (last_item_s) begin
                in_cnt_r   <= '0;
                sel_r      <= '0;
                pass_cnt_r <= last_pass_s ? '0 : pass_cnt_r + PASS_W'(1);
            end else begin
                in_cnt_r   <= in_cnt_r + CNT_BITS'(1);
                sel_r      <= (sel_r == SEL_MAX) ? '0 : sel_r + SEL_W'(1);
            end
        end
    end

    // reduction: load core 0, then one add at a time for cores 1..A-1 in order
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            red_r         <= RD_LOAD;
            idx_r         <= '0;
            acc_r         <= '0;
            operand_r     <= '0;
            load_rdy_r    <= 1'b0;
            add_val_r     <= 1'b0;
            add_res_rdy_r <= 1'b0;
        end else begin
            load_rdy_r <= 1'b0;
            if (start_ok_s) begin
                red_r         <= RD_LOAD;
                idx_r         <= '0;
                acc_r         <= '0;
                add_val_r     <= 1'b0;
                add_res_rdy_r <= 1'b0;
            end else if (state_r == ST_REDUCE) begin
                case (red_r)
                    RD_LOAD: begin
                        if (i_core_res_val[0]) begin
                            acc_r      <= i_core_res_dat[PNT_BITS-1:0];
                            load_rdy_r <= 1'b1;
                            idx_r      <= SEL_W'(1);
                            red_r      <= RD_ISSUE;
                        end
                    end
                    RD_ISSUE: begin
                        if (!add_val_r) begin
                            if (res_val_sel_s) begin
                                add_val_r <= 1'b1;
                                operand_r <= res_dat_sel_s;
                            end
                        end else if (i_add_rdy) begin
                            add_val_r     <= 1'b0;
                            add_res_rdy_r <= 1'b1;
                            red_r         <= RD_WAIT;
                        end
                    end
                    RD_WAIT: begin
                        if (i_add_res_val) begin
                            acc_r         <= i_add_res_dat;
                            add_res_rdy_r <= 1'b0;
                            if (!last_idx_s) begin
                                idx_r <= idx_r + SEL_W'(1);
                                red_r <= RD_ISSUE;
                            end
                        end
                    end
                    default: red_r <= RD_LOAD;
                endcase
            end
        end
    end

    // final result valid, raised on entry to OUTPUT and held until taken
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                                      pnt_val_r <= 1'b0;
        else if ((state_next_s == ST_OUTPUT) && (state_r != ST_OUTPUT)) pnt_val_r <= 1'b1;
        else if (out_fire_s)                                            pnt_val_r <= 1'b0;
    end

`ifdef MULTIEXP_DISPATCH_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] run_cnt_r;

    // saturating stall and busy-cycle counters, cleared by each accepted start
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_r <= 32'd0;
            run_cnt_r   <= 32'd0;
        end else if (start_ok_s) begin
            stall_cnt_r <= 32'd0;
            run_cnt_r   <= 32'd0;
        end else begin
            if ((state_r == ST_DISPATCH) && i_pnt_scl_val && !o_pnt_scl_rdy &&
                (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if ((state_r != ST_IDLE) && (run_cnt_r != 32'hFFFF_FFFF)) begin
                run_cnt_r <= run_cnt_r + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_r;
    assign o_run_cnt   = run_cnt_r;
`endif

endmodule
